decode_stage: RTL and testbench

Parametrised instruction-decode pipeline stage for the MIPS core. It sits between fetch and execute and holds the architectural register file. It splits each instruction into fields, reads operands with forwarding, and extends the immediate. Unlike the earlier fixed-width decode, it adds:
- a valid/ready handshake on both sides;
- flush;
- load-use hazard stalling;
- write-back bypass, including refresh of a held output beat;
- a zero/sign immediate-extension mode;
- width and register-count parameters.

---
 rtl/decode_stage.sv | 125 ++++++++++++
 tb/tb_decode_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS decode stage: register file, operand forwarding, load-use stall, immediate extension
module decode_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int IMM_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_fwd_en,
   input  logic [REG_AW-1:0] ex_fwd_addr,
   input  logic [DATA_W-1:0] ex_fwd_data,
   input  logic              ex_load,
   input  logic [REG_AW-1:0] ex_load_dst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [5:0]        out_opcode,
   output logic [5:0]        out_funct,
   output logic [4:0]        out_shamt,
   output logic [REG_AW-1:0] out_rs,
   output logic [REG_AW-1:0] out_rt,
   output logic [REG_AW-1:0] out_rd,
   output logic [DATA_W-1:0] out_rs_data,
   output logic [DATA_W-1:0] out_rt_data,
   output logic [DATA_W-1:0] out_imm
);

   localparam int NREG = 1 << REG_AW;

   logic [DATA_W-1:0] regs [NREG];

   logic [5:0]        opcode;
   logic [REG_AW-1:0] rs, rt, rd;
   logic              rt_use, zero_ext, hazard, accept;
   logic [DATA_W-1:0] rs_val, rt_val, imm_ext;
   logic [IMM_W-1:0]  imm_raw;
   logic signed [IMM_W-1:0] imm_s;

   assign opcode  = in_instr[31:26];
   assign rs      = in_instr[21 +: REG_AW];
   assign rt      = in_instr[16 +: REG_AW];
   assign rd      = in_instr[11 +: REG_AW];
   assign imm_raw = in_instr[IMM_W-1:0];
   assign imm_s   = imm_raw;

   assign rt_use   = (opcode == 6'h00) || (opcode == 6'h04) || (opcode == 6'h05) || (opcode == 6'h2B);
   assign zero_ext = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
   assign imm_ext  = zero_ext ? DATA_W'(imm_raw) : DATA_W'(imm_s);

   assign hazard   = in_valid && ex_load && (ex_load_dst != '0) &&
                     ((ex_load_dst == rs) || (rt_use && (ex_load_dst == rt)));
   assign in_ready = flush || ((!out_valid || out_ready) && !hazard);
   assign accept   = in_valid && in_ready && !flush;

   // Execute-stage result is younger than write-back, so it takes priority
   function automatic logic [DATA_W-1:0] sel_operand(input logic [REG_AW-1:0] a,
                                                     input logic [DATA_W-1:0] arr_val);
      logic [DATA_W-1:0] v;
      v = arr_val;
      if (a == '0)
         v = '0;
      else if (ex_fwd_en && (ex_fwd_addr == a))
         v = ex_fwd_data;
      else if (wb_en && (wb_addr == a))
         v = wb_data;
      return v;
   endfunction

   always_comb begin
      rs_val = sel_operand(rs, regs[rs]);
      rt_val = sel_operand(rt, regs[rt]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (wb_en && (wb_addr != '0)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_opcode  <= '0;
         out_funct   <= '0;
         out_shamt   <= '0;
         out_rs      <= '0;
         out_rt      <= '0;
         out_rd      <= '0;
         out_rs_data <= '0;
         out_rt_data <= '0;
         out_imm     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         out_opcode  <= opcode;
         out_funct   <= in_instr[5:0];
         out_shamt   <= in_instr[10:6];
         out_rs      <= rs;
         out_rt      <= rt;
         out_rd      <= rd;
         out_rs_data <= rs_val;
         out_rt_data <= rt_val;
         out_imm     <= imm_ext;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end else if (out_valid) begin
         // A stalled beat must not carry a stale operand past a write-back
         if (wb_en && (wb_addr != '0) && (wb_addr == out_rs))
            out_rs_data <= wb_data;
         if (wb_en && (wb_addr != '0) && (wb_addr == out_rt))
            out_rt_data <= wb_data;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, flush;
   logic [31:0] in_instr;
   logic        wb_en, ex_fwd_en, ex_load;
   logic [4:0]  wb_addr, ex_fwd_addr, ex_load_dst;
   logic [31:0] wb_data, ex_fwd_data;
   logic        out_valid, out_ready;
   logic [5:0]  out_opcode, out_funct;
   logic [4:0]  out_shamt, out_rs, out_rt, out_rd;
   logic [31:0] out_rs_data, out_rt_data, out_imm;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   decode_stage #(.DATA_W(32), .REG_AW(5), .IMM_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .flush(flush),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
      .ex_load(ex_load), .ex_load_dst(ex_load_dst),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_funct(out_funct), .out_shamt(out_shamt),
      .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
      .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      ex_fwd_en = 1'b0; ex_fwd_addr = '0; ex_fwd_data = '0;
      ex_load = 1'b0; ex_load_dst = '0; out_ready = 1'b1;
      step(); step();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_rs_data", out_rs_data, 0);
      check("rst_imm", out_imm, 0);
      rst_n = 1'b1;
      step();

      // write r5, then decode add r6,r5,r6
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678;
      step();
      wb_en = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00A6_3020;
      #1;
      check("t1_in_ready", 32'(in_ready), 1);
      check("t1_valid_before", 32'(out_valid), 0);
      step();
      in_valid = 1'b0;
      check("t1_out_valid", 32'(out_valid), 1);
      check("t1_rs", 32'(out_rs), 5);
      check("t1_rs_data", out_rs_data, 32'h1234_5678);
      check("t1_rt_data", out_rt_data, 0);
      check("t1_rd", 32'(out_rd), 6);
      check("t1_funct", 32'(out_funct), 32'h20);
      step();
      check("t1_drained", 32'(out_valid), 0);

      // register zero ignores writes and reads as zero, even with bypass active
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
      step();
      in_valid = 1'b1; in_instr = 32'h0000_0020;
      step();
      in_valid = 1'b0; wb_en = 1'b0;
      check("r0_rs_data", out_rs_data, 0);
      check("r0_rt_data", out_rt_data, 0);
      step();

      // wb-only bypass, then ex forward beats wb, then plain array read
      in_valid = 1'b1; in_instr = 32'h2060_0000;
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_BBBB;
      step();
      check("wb_bypass", out_rs_data, 32'h0000_BBBB);
      ex_fwd_en = 1'b1; ex_fwd_addr = 5'd3; ex_fwd_data = 32'h0000_AAAA;
      step();
      check("fwd_priority", out_rs_data, 32'h0000_AAAA);
      ex_fwd_en = 1'b0; wb_en = 1'b0;
      step();
      in_valid = 1'b0;
      check("array_read", out_rs_data, 32'h0000_BBBB);
      step();

      // load-use hazard on rt of an R-type
      ex_load = 1'b1; ex_load_dst = 5'd4;
      in_valid = 1'b1; in_instr = 32'h0004_2020;
      #1;
      check("lu_in_ready", 32'(in_ready), 0);
      step();
      check("lu_bubble", 32'(out_valid), 0);
      ex_load = 1'b0;
      #1;
      check("lu_release_ready", 32'(in_ready), 1);
      step();
      in_valid = 1'b0;
      check("lu_accepted", 32'(out_valid), 1);
      check("lu_rt", 32'(out_rt), 4);
      step();
      // rt of addi is a destination, so no stall; nor for a load to r0
      ex_load = 1'b1; ex_load_dst = 5'd4; in_valid = 1'b1; in_instr = 32'h2004_0001;
      #1;
      check("lu_rt_not_src", 32'(in_ready), 1);
      ex_load_dst = 5'd0; in_instr = 32'h0000_0020;
      #1;
      check("lu_dst_zero", 32'(in_ready), 1);
      in_valid = 1'b0; ex_load = 1'b0;
      step();

      // backpressure with held-beat refresh
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h20E8_1234;
      step();
      in_valid = 1'b0;
      check("bp_valid", 32'(out_valid), 1);
      check("bp_rs_data0", out_rs_data, 0);
      check("bp_in_ready", 32'(in_ready), 0);
      step();
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_0055;
      step();
      wb_en = 1'b0;
      check("bp_refresh", out_rs_data, 32'h0000_0055);
      check("bp_imm_hold", out_imm, 32'h0000_1234);
      check("bp_rt_hold", 32'(out_rt), 8);
      step();
      check("bp_still_valid", 32'(out_valid), 1);
      out_ready = 1'b1;
      step();
      check("bp_transferred", 32'(out_valid), 0);

      // back-to-back immediates: zero- and sign-extension
      in_valid = 1'b1; in_instr = 32'h3402_8000;
      step();
      check("ori_imm", out_imm, 32'h0000_8000);
      check("ori_opcode", 32'(out_opcode), 32'h0D);
      in_instr = 32'h2002_8000;
      step();
      in_valid = 1'b0;
      check("addi_valid", 32'(out_valid), 1);
      check("addi_imm", out_imm, 32'hFFFF_8000);

      // flush a held beat plus an incoming beat
      out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_instr = 32'h3402_FFFF;
      #1;
      check("fl_in_ready", 32'(in_ready), 1);
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check("fl_out_valid", 32'(out_valid), 0);
      step();
      check("fl_never_presented", 32'(out_valid), 0);

      // asynchronous reset in the middle of a held beat
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h20E8_1234;
      step();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 0);
      check("arst_imm", out_imm, 0);
      step();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
